hwpe_ctrl_uloop_sequencer: RTL and testbench

Control stage that sits between the HWPE controller FSM and the streamers, directly downstream of the uloop microcode engine. It steps the uloop one iteration at a time, forming one address bundle per iteration from each base address plus the matching uloop offset register. It issues that bundle to up to NB_STREAMS streamers over independent valid/ready channels and reports termination when the uloop flags `done`.

---
 rtl/hwpe_ctrl_uloop_sequencer.sv | 166 ++++++++++++++++
 tb/tb_hwpe_ctrl_uloop_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_uloop_sequencer.sv
// Steps the uloop one iteration at a time and issues one base+offset address
// bundle per iteration to NB_STREAMS independent valid/ready channels.
module hwpe_ctrl_uloop_sequencer #(
  parameter int unsigned NB_STREAMS = 4,
  parameter int unsigned NB_REG     = 4,
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  clear_i,
  input  logic                                  start_i,
  input  logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0] base_addr_i,
  input  logic [NB_STREAMS-1:0]                 stream_en_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [CNT_WIDTH-1:0]                  nb_iter_o,
  output logic                                  uloop_enable_o,
  output logic                                  uloop_clear_o,
  input  logic                                  uloop_valid_i,
  input  logic                                  uloop_done_i,
  input  logic [NB_REG-1:0][REG_WIDTH-1:0]      uloop_offs_i,
  output logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0] stream_addr_o,
  output logic [NB_STREAMS-1:0]                 stream_valid_o,
  input  logic [NB_STREAMS-1:0]                 stream_ready_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    FETCH  = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4
  } state_e;

  state_e                                state_r, state_s;
  logic [NB_STREAMS-1:0]                 mask_r, pending_r, pending_left_s;
  logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0] base_r, addr_r, next_addr_s;
  logic [CNT_WIDTH-1:0]                  cnt_r;
  logic                                  uclear_r;

  // Zero-extend (or truncate) a uloop offset register to address width.
  function automatic logic [ADDR_WIDTH-1:0] offs_ext(input logic [REG_WIDTH-1:0] offs);
    logic [ADDR_WIDTH+REG_WIDTH-1:0] wide;
    wide = {{ADDR_WIDTH{1'b0}}, offs};
    return wide[ADDR_WIDTH-1:0];
  endfunction

  // Channels still waiting after this cycle's handshakes.
  always_comb begin
    pending_left_s = pending_r & ~stream_ready_i;
  end

  // Next bundle addresses, modulo 2^ADDR_WIDTH.
  always_comb begin
    next_addr_s = base_r;
    for (int i = 0; i < NB_STREAMS; i++) begin
      next_addr_s[i] = base_r[i] + offs_ext(uloop_offs_i[i]);
    end
  end

  // State register; clear behaves like reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else if (clear_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) state_s = ISSUE;
        else         state_s = IDLE;
      end
      ISSUE: begin
        if (pending_left_s == {NB_STREAMS{1'b0}}) state_s = FETCH;
        else                                      state_s = ISSUE;
      end
      FETCH: state_s = WAIT;
      WAIT: begin
        if (uloop_valid_i) begin
          if (uloop_done_i) state_s = FINISH;
          else              state_s = ISSUE;
        end else begin
          state_s = WAIT;
        end
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Captured configuration, pending mask, addresses and bundle counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_r    <= {NB_STREAMS{1'b0}};
      pending_r <= {NB_STREAMS{1'b0}};
      base_r    <= {(NB_STREAMS*ADDR_WIDTH){1'b0}};
      addr_r    <= {(NB_STREAMS*ADDR_WIDTH){1'b0}};
      cnt_r     <= {CNT_WIDTH{1'b0}};
      uclear_r  <= 1'b0;
    end else if (clear_i) begin
      mask_r    <= {NB_STREAMS{1'b0}};
      pending_r <= {NB_STREAMS{1'b0}};
      base_r    <= {(NB_STREAMS*ADDR_WIDTH){1'b0}};
      addr_r    <= {(NB_STREAMS*ADDR_WIDTH){1'b0}};
      cnt_r     <= {CNT_WIDTH{1'b0}};
      uclear_r  <= 1'b0;
    end else begin
      uclear_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_i) begin
            base_r    <= base_addr_i;
            addr_r    <= base_addr_i;
            mask_r    <= stream_en_i;
            pending_r <= stream_en_i;
            cnt_r     <= {CNT_WIDTH{1'b0}};
            uclear_r  <= 1'b1;
          end
        end
        ISSUE: begin
          pending_r <= pending_left_s;
          if (pending_left_s == {NB_STREAMS{1'b0}}) cnt_r <= cnt_r + CNT_WIDTH'(1);
        end
        WAIT: begin
          if (uloop_valid_i && !uloop_done_i) begin
            addr_r    <= next_addr_s;
            pending_r <= mask_r;
          end
        end
        default: begin
          pending_r <= pending_r;
        end
      endcase
    end
  end

  // Output decode from registered state and pending mask only.
  always_comb begin
    busy_o         = 1'b1;
    done_o         = 1'b0;
    uloop_enable_o = 1'b0;
    stream_valid_o = {NB_STREAMS{1'b0}};
    case (state_r)
      IDLE:    busy_o         = 1'b0;
      ISSUE:   stream_valid_o = pending_r;
      FETCH:   uloop_enable_o = 1'b1;
      WAIT:    busy_o         = 1'b1;
      FINISH:  done_o         = 1'b1;
      default: busy_o         = 1'b0;
    endcase
  end

  assign uloop_clear_o = uclear_r;
  assign stream_addr_o = addr_r;
  assign nb_iter_o     = cnt_r;

endmodule

// File: tb/tb_hwpe_ctrl_uloop_sequencer.sv
// Scoreboard bench: expected per-channel addresses are queued at start and
// popped on every handshake; a small uloop model answers each step request.
module tb_hwpe_ctrl_uloop_sequencer;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              clear_i = 1'b0;
  logic              start_i = 1'b0;
  logic [3:0][31:0]  base_addr_i = '0;
  logic [3:0]        stream_en_i = 4'h0;
  logic              busy_o, done_o, uloop_enable_o, uloop_clear_o;
  logic [15:0]       nb_iter_o;
  logic              uloop_valid_i = 1'b0;
  logic              uloop_done_i = 1'b0;
  logic [3:0][31:0]  uloop_offs_i = '0;
  logic [3:0][31:0]  stream_addr_o;
  logic [3:0]        stream_valid_o;
  logic [3:0]        stream_ready_i = 4'h0;

  // narrow-register instance for offset zero-extension
  logic              s_clear = 1'b0, s_start = 1'b0;
  logic [0:0][31:0]  s_base = '0;
  logic              s_busy, s_done, s_en, s_uclr;
  logic [15:0]       s_iter;
  logic [0:0][15:0]  s_offs = '{16'hFFFF};
  logic [0:0][31:0]  s_addr;
  logic [0:0]        s_valid;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] base_cfg [4];
  logic [31:0] step_cfg [4];
  logic [31:0] exp_q [4][$];
  int          hold [4];
  int          n_iter_cfg = 0;
  bit          chk_en = 1'b1;

  always #5 clk_i = ~clk_i;

  hwpe_ctrl_uloop_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .stream_en_i(stream_en_i),
    .busy_o(busy_o), .done_o(done_o), .nb_iter_o(nb_iter_o),
    .uloop_enable_o(uloop_enable_o), .uloop_clear_o(uloop_clear_o),
    .uloop_valid_i(uloop_valid_i), .uloop_done_i(uloop_done_i),
    .uloop_offs_i(uloop_offs_i), .stream_addr_o(stream_addr_o),
    .stream_valid_o(stream_valid_o), .stream_ready_i(stream_ready_i)
  );

  hwpe_ctrl_uloop_sequencer #(.NB_STREAMS(1), .NB_REG(1), .REG_WIDTH(16)) dut16 (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(s_clear), .start_i(s_start),
    .base_addr_i(s_base), .stream_en_i(1'b1),
    .busy_o(s_busy), .done_o(s_done), .nb_iter_o(s_iter),
    .uloop_enable_o(s_en), .uloop_clear_o(s_uclr),
    .uloop_valid_i(1'b1), .uloop_done_i(1'b0),
    .uloop_offs_i(s_offs), .stream_addr_o(s_addr),
    .stream_valid_o(s_valid), .stream_ready_i(1'b1)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // uloop model: answers one cycle after each enable with offs = k*step
  initial begin
    int  k;
    bit  en_prev;
    k = 0;
    en_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (uloop_clear_o) k = 0;
      if (en_prev) begin
        k++;
        uloop_valid_i = 1'b1;
        uloop_done_i  = (k > n_iter_cfg);
        for (int i = 0; i < 4; i++) uloop_offs_i[i] = step_cfg[i] * k;
      end else begin
        uloop_valid_i = 1'b0;
        uloop_done_i  = 1'b0;
      end
      en_prev = uloop_enable_o;
    end
  end

  // ready driver, handshake scoreboard and valid/address stability monitor
  initial begin
    logic [3:0]       pv, phs;
    logic [3:0][31:0] paddr;
    logic [31:0]      e;
    pv = 4'h0;
    phs = 4'h0;
    paddr = '0;
    forever begin
      @(negedge clk_i);
      for (int i = 0; i < 4; i++) begin
        stream_ready_i[i] = (hold[i] == 0);
        if (busy_o && hold[i] > 0) hold[i]--;
      end
      for (int i = 0; i < 4; i++) begin
        if (chk_en && pv[i] && !phs[i]) begin
          check_eq($sformatf("valid_hold%0d", i), {63'd0, stream_valid_o[i]}, 64'd1);
          check_eq($sformatf("addr_stable%0d", i), {32'd0, stream_addr_o[i]}, {32'd0, paddr[i]});
        end
        if (stream_valid_o[i] && stream_ready_i[i]) begin
          if (exp_q[i].size() == 0) begin
            check_eq($sformatf("unexpected_valid%0d", i), 64'd1, 64'd0);
          end else begin
            e = exp_q[i].pop_front();
            check_eq($sformatf("addr%0d", i), {32'd0, stream_addr_o[i]}, {32'd0, e});
          end
        end
        pv[i]    = stream_valid_o[i];
        phs[i]   = stream_valid_o[i] & stream_ready_i[i];
        paddr[i] = stream_addr_o[i];
      end
    end
  end

  task automatic run_loop(input logic [3:0] mask, input int n, input int stall, input bit busy_start);
    int          cyc;
    logic [31:0] a;
    n_iter_cfg = n;
    for (int k = 0; k <= n; k++)
      for (int i = 0; i < 4; i++)
        if (mask[i]) begin
          a = base_cfg[i] + step_cfg[i] * k;
          exp_q[i].push_back(a);
        end
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) base_addr_i[i] = base_cfg[i];
    stream_en_i = mask;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc = 1;
    check_eq("busy_c1", {63'd0, busy_o}, 64'd1);
    check_eq("uclear_c1", {63'd0, uloop_clear_o}, 64'd1);
    check_eq("valid_c1", {60'd0, stream_valid_o}, {60'd0, mask});
    check_eq("iter_c1", {48'd0, nb_iter_o}, 64'd0);
    while (done_o !== 1'b1 && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
      if (busy_start) start_i = (cyc == 2);
      if (stall > 0 && cyc == 2)
        check_eq("skew_valid_c2", {60'd0, stream_valid_o}, 64'h4);
    end
    start_i = 1'b0;
    check_eq("done_cycle", cyc, 3 * (n + 1) + 1 + stall);
    @(negedge clk_i);
    check_eq("done_pulse", {63'd0, done_o}, 64'd0);
    check_eq("busy_idle", {63'd0, busy_o}, 64'd0);
    check_eq("nb_iter", {48'd0, nb_iter_o}, n + 1);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("sb_left%0d", i), exp_q[i].size(), 64'd0);
    @(negedge clk_i);
    check_eq("nb_iter_hold", {48'd0, nb_iter_o}, n + 1);
  endtask

  task automatic set_basic();
    for (int i = 0; i < 4; i++) begin
      base_cfg[i] = 32'h1000 * (i + 1);
      step_cfg[i] = 32'd4 * (i + 1);
      hold[i] = 0;
    end
  endtask

  initial begin
    set_basic();
    repeat (2) @(negedge clk_i);
    check_eq("rst_busy", {63'd0, busy_o}, 64'd0);
    check_eq("rst_valid", {60'd0, stream_valid_o}, 64'd0);
    check_eq("rst_addr", stream_addr_o[1:0], 64'd0);
    check_eq("rst_misc", {60'd0, done_o, uloop_enable_o, uloop_clear_o, 1'b0}, 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_eq("rst_iter", {48'd0, nb_iter_o}, 64'd0);

    // basic loop
    run_loop(4'hF, 1, 0, 1'b0);
    // skewed backpressure on stream 2
    hold[2] = 5;
    run_loop(4'hF, 1, 5, 1'b0);
    // masked streams
    run_loop(4'b0101, 1, 0, 1'b0);
    run_loop(4'h0, 2, 0, 1'b0);
    // address wrap
    base_cfg[0] = 32'hFFFF_FFF0;
    step_cfg[0] = 32'h20;
    run_loop(4'h1, 1, 0, 1'b0);
    set_basic();
    // immediate done with a start pulsed while busy
    run_loop(4'hF, 0, 0, 1'b1);

    // clear mid-ISSUE with a simultaneous start
    hold[1] = 100;
    hold[3] = 100;
    for (int i = 0; i < 4; i++) begin
      base_addr_i[i] = base_cfg[i];
      exp_q[i].push_back(base_cfg[i]);
    end
    n_iter_cfg = 1;
    stream_en_i = 4'hF;
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(posedge clk_i);
    chk_en = 1'b0;
    @(negedge clk_i);
    check_eq("clr_pending", {60'd0, stream_valid_o}, 64'hA);
    clear_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    start_i = 1'b0;
    check_eq("clr_busy", {63'd0, busy_o}, 64'd0);
    check_eq("clr_valid", {60'd0, stream_valid_o}, 64'd0);
    check_eq("clr_iter", {48'd0, nb_iter_o}, 64'd0);
    check_eq("clr_addr", stream_addr_o[0], 64'd0);
    @(negedge clk_i);
    check_eq("clr_start_ignored", {63'd0, busy_o}, 64'd0);
    @(posedge clk_i);
    hold[1] = 0;
    hold[3] = 0;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    chk_en = 1'b1;
    run_loop(4'hF, 1, 0, 1'b0);

    // 16-bit offset register must be zero-extended
    s_base[0] = 32'h0001_0000;
    @(negedge clk_i);
    s_start = 1'b1;
    @(negedge clk_i);
    s_start = 1'b0;
    check_eq("ext_base", {32'd0, s_addr[0]}, 64'h0001_0000);
    repeat (3) @(negedge clk_i);
    check_eq("ext_valid", {63'd0, s_valid[0]}, 64'd1);
    check_eq("ext_addr", {32'd0, s_addr[0]}, 64'h0001_FFFF);
    s_clear = 1'b1;
    @(negedge clk_i);
    s_clear = 1'b0;
    check_eq("ext_clear", {63'd0, s_busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
